// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues single-outstanding fetches
// over req/gnt/rvalid, buffers responses in a small FIFO and hands
// {instruction, PC} to decode. Redirects flush the buffer and drop the
// in-flight response.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_ent_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_pc, w_pc_nxt, r_req_pc;
  logic          r_stale, w_stale_nxt;
  fetch_ent_t    r_mem [FIFO_DEPTH];
  fetch_ent_t    w_head;
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          w_gnt, w_push, w_pop, w_space, w_space_after, w_idle_ok;
  logic [31:0]   w_redir_pc;

  assign w_redir_pc    = redirect_pc & ~32'h3;
  assign w_gnt         = (r_state == REQ) && imem_gnt;
  assign w_push        = (r_state == WAIT) && imem_rvalid && !r_stale && !redirect_valid;
  assign w_pop         = instr_valid && instr_ready && !redirect_valid;
  assign w_count_nxt   = redirect_valid ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
  assign w_space       = (r_count + CW'(r_state == WAIT)) < DEPTH_C;
  assign w_space_after = w_count_nxt < DEPTH_C;
  // An abandoned response (from before a reset) must come back before a new
  // request goes out, otherwise it would be mistaken for the new one.
  assign w_idle_ok     = !r_stale || imem_rvalid;

  assign imem_req    = (r_state == REQ);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_count != '0);
  assign w_head      = r_mem[r_head];
  assign instr_out   = instr_valid ? w_head.instr : '0;
  assign instr_pc    = instr_valid ? w_head.pc    : '0;

  // Next-state, next-PC and stale tracking; redirect wins over sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_stale_nxt = r_stale;
    if (r_stale && imem_rvalid) w_stale_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
          if (w_idle_ok) w_state_nxt = REQ;
        end else if (w_space && w_idle_ok) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
          if (imem_gnt) begin
            w_stale_nxt = 1'b1;
            w_state_nxt = WAIT;
          end
        end else if (imem_gnt) begin
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
          if (imem_rvalid) begin
            w_stale_nxt = 1'b0;
            w_state_nxt = REQ;
          end else begin
            w_stale_nxt = 1'b1;
          end
        end else if (imem_rvalid) begin
          w_stale_nxt = 1'b0;
          w_state_nxt = w_space_after ? REQ : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control state; on reset any still-outstanding response is marked stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
      r_stale  <= ((r_stale || (r_state == WAIT)) && !imem_rvalid) || w_gnt;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_stale <= w_stale_nxt;
      if (w_gnt) r_req_pc <= r_pc;
    end
  end

  // FIFO pointers and occupancy; redirect empties the buffer.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      r_count <= w_count_nxt;
    end
  end

  // FIFO storage, written on accepted responses only.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_tail] <= '{instr: imem_rdata, pc: r_req_pc};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && (r_count == DEPTH_C)));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: random-latency memory, random decode
// backpressure, redirects and resets, checked by a fetch-order model and a
// response scoreboard.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_gnt, imem_rvalid, redirect_valid;
  logic        instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr_out, instr_pc;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  exp_t q[$];

  int total = 0, bad = 0, cyc = 0;
  int k_gnt = 100, k_rd = 0, k_rdy = 100, k_redir = 0, k_rst = 0;
  bit busy = 0; int cnt = 0;
  logic [31:0] mem_addr = '0, g_addr = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction
  function automatic logic [31:0] al(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] rnd_target();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return $urandom;
  endfunction

  // One cycle of stimulus: memory model, decode, redirect, reset.
  // rmode: 0 random, 1 always, 2 with grant, 3 with rvalid, 4 in WAIT on 0x10
  task automatic step(input int rmode, input logic [31:0] tgt, input bit do_rst,
                      output bit fired);
    @(posedge clk); #1;
    if (imem_gnt) begin busy = 1; cnt = $urandom_range(0, k_rd); mem_addr = g_addr; end
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (busy) begin
      if (cnt == 0) begin imem_rvalid = 1'b1; imem_rdata = memf(mem_addr); busy = 0; end
      else cnt--;
    end
    imem_gnt = imem_req && !busy && ($urandom_range(0, 99) < k_gnt);
    if (imem_gnt) g_addr = imem_addr;
    instr_ready = ($urandom_range(0, 99) < k_rdy);
    case (rmode)
      1:       fired = 1'b1;
      2:       fired = imem_gnt;
      3:       fired = imem_rvalid;
      4:       fired = busy && !imem_rvalid && (mem_addr == 32'h10);
      default: fired = 1'b0;
    endcase
    redirect_valid = fired || ($urandom_range(0, 999) < k_redir);
    redirect_pc    = fired ? tgt : rnd_target();
    reset = do_rst || (k_rst > 0 && busy && !imem_req && ($urandom_range(0, 999) < k_rst));
  endtask

  // Monitor: reset/redirect aftermath and decode handshakes vs. the scoreboard.
  bit rst_seen = 0, rd_seen = 0, lat_arm = 0, lat_arm_g = 0;
  logic [31:0] rd_tgt = '0, exp_pc = RST_PC;
  int n_hs = 0, t_g = -1, t_v = -1;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_seen) begin
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_valid", instr_valid, 0);
      chk("rst_out", instr_out, 0);
      chk("rst_pc", instr_pc, 0);
    end else if (rd_seen) begin
      chk("redir_empty", instr_valid, 0);
      chk("redir_addr", imem_addr, rd_tgt);
    end
    chk("valid_vs_model", instr_valid, q.size() != 0);
    if (instr_valid && instr_ready && !redirect_valid && !reset) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL hs_unexpected actual=pc %h required=no instruction", instr_pc);
      end else begin
        e = q.pop_front();
        chk("hs_sb_pc", instr_pc, e.pc);
        chk("hs_sb_data", instr_out, e.data);
      end
      chk("hs_pc_seq", instr_pc, exp_pc);
      chk("hs_data", instr_out, memf(exp_pc));
      exp_pc += 32'd4;
      n_hs++;
    end
    if (instr_valid && lat_arm) begin t_v = cyc; lat_arm = 0; end
    if (reset) exp_pc = RST_PC;
    else if (redirect_valid) exp_pc = al(redirect_pc);
    rst_seen = reset;
    rd_seen  = redirect_valid && !reset;
    rd_tgt   = al(redirect_pc);
  end

  // Reference model: expected fetch address stream and legitimate responses.
  logic [31:0] fetch_pc = RST_PC, pend_addr = '0;
  bit pend = 0, pend_ok = 0;
  int n_gnt = 0;
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (imem_rvalid && pend) begin
      if (pend_ok && !reset && !redirect_valid) begin
        e.pc = pend_addr; e.data = memf(pend_addr);
        q.push_back(e);
        chk("fifo_bound", q.size() <= DEPTH, 1);
      end
      pend = 0;
    end
    if (reset || redirect_valid) begin q.delete(); pend_ok = 0; end
    if (imem_req && imem_gnt) begin
      chk("gnt_addr", imem_addr, fetch_pc);
      pend = 1; pend_addr = fetch_pc; pend_ok = !reset && !redirect_valid;
      n_gnt++;
      if (lat_arm_g) begin t_g = cyc; lat_arm_g = 0; end
    end
    if (reset) fetch_pc = RST_PC;
    else if (redirect_valid) fetch_pc = al(redirect_pc);
    else if (imem_req && imem_gnt) fetch_pc += 32'd4;
  end

  task automatic quiesce_reset();
    bit fd;
    k_gnt = 0; k_redir = 0; k_rst = 0;
    repeat (8) step(0, '0, 0, fd);
    step(0, '0, 1, fd);
  endtask

  initial begin
    bit fd;
    int g0, h0, n;
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    // zero-wait memory, free decode
    k_gnt = 100; k_rd = 0; k_rdy = 100;
    repeat (3) step(0, '0, 1, fd);
    chk("no_req_in_reset", imem_req, 0);
    lat_arm = 1; lat_arm_g = 1; h0 = n_hs;
    repeat (14) step(0, '0, 0, fd);
    chk("latency", t_v - t_g, 2);
    chk("p1_progress", (n_hs - h0) >= 3, 1);

    // backpressure: buffer fills, fetching stops, then drains and resumes
    quiesce_reset();
    k_gnt = 100; k_rd = 0; k_rdy = 0; g0 = n_gnt;
    repeat (12) step(0, '0, 0, fd);
    chk("bp_req_low", imem_req, 0);
    chk("bp_fetched", n_gnt - g0, DEPTH);
    chk("bp_valid", instr_valid, 1);
    k_rdy = 100;
    repeat (12) step(0, '0, 0, fd);
    chk("bp_resume", (n_gnt - g0) >= 4, 1);

    // redirect while waiting on 0x10
    quiesce_reset();
    k_gnt = 100; k_rd = 3; k_rdy = 100; n = 0; fd = 0;
    while (!fd && n < 200) begin step(4, 32'h100, 0, fd); n++; end
    chk("p3_fired", fd, 1);
    step(0, '0, 0, fd);
    chk("p3_addr", imem_addr, 32'h100);
    h0 = n_hs;
    repeat (30) step(0, '0, 0, fd);
    chk("p3_progress", (n_hs - h0) >= 2, 1);

    // misaligned redirect coincident with grant, then with rvalid
    k_rd = 0; n = 0; fd = 0;
    while (!fd && n < 100) begin step(2, 32'h203, 0, fd); n++; end
    chk("p4a_fired", fd, 1);
    repeat (12) step(0, '0, 0, fd);
    n = 0; fd = 0;
    while (!fd && n < 100) begin step(3, 32'h203, 0, fd); n++; end
    chk("p4b_fired", fd, 1);
    h0 = n_hs;
    repeat (12) step(0, '0, 0, fd);
    chk("p4_progress", (n_hs - h0) >= 2, 1);

    // address wrap
    step(1, 32'hFFFF_FFFC, 0, fd);
    h0 = n_hs;
    repeat (16) step(0, '0, 0, fd);
    chk("wrap_progress", (n_hs - h0) >= 3, 1);

    // random traffic with redirects and resets mid-transaction
    k_gnt = 60; k_rd = 5; k_rdy = 70; k_redir = 30; k_rst = 20;
    h0 = n_hs;
    repeat (3000) step(0, '0, 0, fd);
    chk("rand_progress", (n_hs - h0) > 100, 1);

    // drain
    k_gnt = 100; k_rd = 0; k_rdy = 100; k_redir = 0; k_rst = 0;
    repeat (20) step(0, '0, 0, fd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
